pwm_duty_ramp: RTL



---
 rtl/pwm_duty_ramp_if.sv | 23 ++
 rtl/pwm_duty_ramp.sv | 69 ++++++
 2 files changed

// File: rtl/pwm_duty_ramp_if.sv
// pwm_duty_ramp_if: target handshake, ramp controls and duty/status outputs of the duty ramp
interface pwm_duty_ramp_if #(
  parameter int DUTY_W = 4,
  parameter int DIV_W  = 8
);
  logic              tick;
  logic              enable;
  logic [DUTY_W-1:0] target_duty;
  logic              target_valid;
  logic              target_ready;
  logic [DIV_W-1:0]  step_div;
  logic [DUTY_W-1:0] duty;
  logic              busy;
  logic              done;
  modport master (
    output tick, enable, target_duty, target_valid, step_div,
    input  target_ready, duty, busy, done
  );
  modport slave (
    input  tick, enable, target_duty, target_valid, step_div,
    output target_ready, duty, busy, done
  );
endinterface

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: slews a PWM duty one LSB per (step_div+1) accepted ticks toward a handshaked target
module pwm_duty_ramp #(
  parameter int DUTY_W = 4,
  parameter int DIV_W  = 8
) (
  input logic           clk,
  input logic           rst,
  pwm_duty_ramp_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RAMP, PAUSE} state_t;
  state_t            state, state_n;
  logic [DUTY_W-1:0] tgt, tgt_n, duty_q, duty_n;
  logic [DIV_W-1:0]  div, div_n, presc, presc_n;
  logic              done_q, done_n, busy_q, ready_q;
  assign bus.duty         = duty_q;
  assign bus.done         = done_q & rst;
  assign bus.busy         = busy_q & rst;
  assign bus.target_ready = ready_q & rst;
  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    div_n   = div;
    presc_n = presc;
    duty_n  = duty_q;
    done_n  = 1'b0;
    case (state)
      IDLE: if (bus.target_valid && ready_q) begin
        tgt_n   = bus.target_duty;
        div_n   = bus.step_div;
        presc_n = '0;
        done_n  = bus.target_duty == duty_q;
        state_n = done_n ? IDLE : RAMP;
      end
      RAMP: if (!bus.enable) state_n = PAUSE;
      else if (bus.tick) begin
        // a step is only taken while duty != tgt, so duty can never wrap
        if (presc == div) begin
          presc_n = '0;
          duty_n  = tgt > duty_q ? duty_q + 1'b1 : duty_q - 1'b1;
          done_n  = duty_n == tgt;
          state_n = done_n ? IDLE : RAMP;
        end else presc_n = presc + 1'b1;
      end
      PAUSE: state_n = bus.enable ? RAMP : PAUSE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      tgt     <= '0;
      div     <= '0;
      presc   <= '0;
      duty_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      tgt     <= tgt_n;
      div     <= div_n;
      presc   <= presc_n;
      duty_q  <= duty_n;
      done_q  <= done_n;
      busy_q  <= state_n != IDLE;
      ready_q <= state_n == IDLE;
    end
  end
endmodule
